// File: rtl/icache_pkg.sv
// Shared definitions for the instruction cache: address/data types, boolean
// constants, default geometry and the controller state encoding.
// No ports; imported by icache and icache_array.
package icache_pkg;

    localparam int ADDR_WIDTH = 32;
    localparam int DATA_WIDTH = 32;

    typedef logic [ADDR_WIDTH-1:0] ADDR_TYPE;
    typedef logic [DATA_WIDTH-1:0] DATA_TYPE;

    localparam logic TRUE  = 1'b1;
    localparam logic FALSE = 1'b0;

    // 256 direct-mapped one-word lines, tag = pc[17:10] (18-bit physical space)
    localparam int ICACHE_INDEX_BITS = 8;
    localparam int ICACHE_TAG_BITS   = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MISS = 2'd1,
        HOLD = 2'd2
    } ic_state_e;

    // Mask of the pc bits that take part in index/tag lookup; everything else
    // (byte offset and bits above the tag) is ignored by the cache.
    function automatic ADDR_TYPE pc_used_mask(input int index_bits, input int tag_bits);
        ADDR_TYPE m;
        m = '0;
        for (int b = 2; b < 2 + index_bits + tag_bits; b++) begin
            if (b < ADDR_WIDTH) begin
                m[b] = 1'b1;
            end
        end
        return m;
    endfunction

endpackage

// File: rtl/icache_array.sv
// Direct-mapped line storage: valid bits, tags and one data word per line.
// Ports: clk_i/rst_i (sync, active-high, clears valid bits only); rd_index_i ->
// rd_valid_o/rd_tag_o/rd_data_o (combinational read); wr_en_i/wr_index_i/wr_tag_i/wr_data_i (write on posedge).
module icache_array
    import icache_pkg::*;
#(
    parameter int INDEX_BITS = ICACHE_INDEX_BITS,
    parameter int TAG_BITS   = ICACHE_TAG_BITS
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [INDEX_BITS-1:0] rd_index_i,
    output logic                  rd_valid_o,
    output logic [TAG_BITS-1:0]   rd_tag_o,
    output DATA_TYPE              rd_data_o,
    input  logic                  wr_en_i,
    input  logic [INDEX_BITS-1:0] wr_index_i,
    input  logic [TAG_BITS-1:0]   wr_tag_i,
    input  DATA_TYPE              wr_data_i
);

    localparam int LINES = 1 << INDEX_BITS;

    logic [LINES-1:0]    valid_q;
    logic [TAG_BITS-1:0] tag_q  [LINES];
    DATA_TYPE            data_q [LINES];

    // Only the valid bits need a reset; stale tag/data behind a cleared valid
    // bit can never produce a hit.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q <= '0;
        end else if (wr_en_i) begin
            valid_q[wr_index_i] <= TRUE;
        end
    end

    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            tag_q[wr_index_i]  <= wr_tag_i;
            data_q[wr_index_i] <= wr_data_i;
        end
    end

    assign rd_valid_o = valid_q[rd_index_i];
    assign rd_tag_o   = tag_q[rd_index_i];
    assign rd_data_o  = data_q[rd_index_i];

endmodule

// File: rtl/icache.sv
// Direct-mapped instruction cache controller: 1-cycle hit, single outstanding
// miss to the memory controller with fill forwarding, flush and freeze support.
// Ports: clk/rst (sync, active-high), rdy (freeze), clr (flush); IF side
// if_to_ic_enable/if_to_ic_pc -> ic_to_if_done/ic_to_if_inst; MC side
// ic_to_mc_enable/ic_to_mc_pc -> mc_to_ic_done/mc_to_ic_result.
module icache
    import icache_pkg::*;
#(
    parameter int INDEX_BITS = ICACHE_INDEX_BITS,
    parameter int TAG_BITS   = ICACHE_TAG_BITS
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     rdy,
    input  logic     clr,
    input  logic     if_to_ic_enable,
    input  ADDR_TYPE if_to_ic_pc,
    output logic     ic_to_if_done,
    output DATA_TYPE ic_to_if_inst,
    output logic     ic_to_mc_enable,
    output ADDR_TYPE ic_to_mc_pc,
    input  logic     mc_to_ic_done,
    input  DATA_TYPE mc_to_ic_result
);

    localparam int       IDX_LSB = 2;
    localparam int       IDX_MSB = IDX_LSB + INDEX_BITS - 1;
    localparam int       TAG_LSB = IDX_MSB + 1;
    localparam int       TAG_MSB = TAG_LSB + TAG_BITS - 1;
    localparam ADDR_TYPE PC_USED = pc_used_mask(INDEX_BITS, TAG_BITS);

    ic_state_e state_q, state_d;
    logic      done_q, done_d;
    DATA_TYPE  inst_q, inst_d;
    logic      mc_en_q, mc_en_d;
    ADDR_TYPE  mc_pc_q, mc_pc_d;
    logic      discard_q, discard_d;

    logic                  rd_valid;
    logic [TAG_BITS-1:0]   rd_tag;
    DATA_TYPE              rd_data;
    logic                  wr_en;
    logic                  hit;
    logic                  unused_pc_bits;

    // Byte offset and bits above the tag never influence the lookup.
    assign unused_pc_bits = ^(if_to_ic_pc & ~PC_USED);

    icache_array #(
        .INDEX_BITS (INDEX_BITS),
        .TAG_BITS   (TAG_BITS)
    ) u_array (
        .clk_i      (clk),
        .rst_i      (rst),
        .rd_index_i (if_to_ic_pc[IDX_MSB:IDX_LSB]),
        .rd_valid_o (rd_valid),
        .rd_tag_o   (rd_tag),
        .rd_data_o  (rd_data),
        .wr_en_i    (wr_en),
        .wr_index_i (mc_pc_q[IDX_MSB:IDX_LSB]),
        .wr_tag_i   (mc_pc_q[TAG_MSB:TAG_LSB]),
        .wr_data_i  (mc_to_ic_result)
    );

    assign hit = rd_valid && (rd_tag == if_to_ic_pc[TAG_MSB:TAG_LSB]);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            done_q    <= FALSE;
            inst_q    <= '0;
            mc_en_q   <= FALSE;
            mc_pc_q   <= '0;
            discard_q <= FALSE;
        end else begin
            state_q   <= state_d;
            done_q    <= done_d;
            inst_q    <= inst_d;
            mc_en_q   <= mc_en_d;
            mc_pc_q   <= mc_pc_d;
            discard_q <= discard_d;
        end
    end

    // done/inst default to zero every cycle so done is a single-cycle pulse and
    // inst reads zero whenever done is low; everything else holds by default,
    // which is also exactly the freeze behaviour when rdy is low.
    always_comb begin
        state_d   = state_q;
        done_d    = FALSE;
        inst_d    = '0;
        mc_en_d   = mc_en_q;
        mc_pc_d   = mc_pc_q;
        discard_d = discard_q;
        wr_en     = FALSE;

        if (rdy) begin
            unique case (state_q)
                IDLE: begin
                    if (if_to_ic_enable && !clr) begin
                        if (hit) begin
                            done_d = TRUE;
                            inst_d = rd_data;
                        end else begin
                            mc_en_d = TRUE;
                            mc_pc_d = if_to_ic_pc;
                            state_d = MISS;
                        end
                    end
                end
                MISS: begin
                    // The transfer always completes and fills the line; clr only
                    // suppresses handing the word to IF.
                    if (mc_to_ic_done) begin
                        wr_en   = TRUE;
                        mc_en_d = FALSE;
                        state_d = HOLD;
                        if (!clr && !discard_q) begin
                            done_d = TRUE;
                            inst_d = mc_to_ic_result;
                        end else begin
                            discard_d = TRUE;
                        end
                    end else if (clr) begin
                        discard_d = TRUE;
                    end
                end
                HOLD: begin
                    // One cycle with enable low so the controller sees the
                    // deassertion before any new miss; requests here are dropped.
                    state_d   = IDLE;
                    discard_d = FALSE;
                end
                default: begin
                    state_d   = IDLE;
                    mc_en_d   = FALSE;
                    discard_d = FALSE;
                end
            endcase
        end
    end

    assign ic_to_if_done   = done_q;
    assign ic_to_if_inst   = inst_q;
    assign ic_to_mc_enable = mc_en_q;
    assign ic_to_mc_pc     = mc_pc_q;

endmodule

// File: tb/tb_icache.sv
// Self-checking bench for icache: directed scenarios plus randomized fetches
// checked against a line-level model of a direct-mapped cache.
module tb_icache;

    logic        clk = 1'b0;
    logic        rst, rdy, clr, if_en, mc_done;
    logic [31:0] if_pc, mc_res;
    logic        if_done, mc_en;
    logic [31:0] if_inst, mc_pc;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: what each line holds, by index.
    bit          m_valid [256];
    logic [7:0]  m_tag   [256];
    logic [31:0] m_data  [256];

    always #5 clk = ~clk;

    icache dut (
        .clk             (clk),
        .rst             (rst),
        .rdy             (rdy),
        .clr             (clr),
        .if_to_ic_enable (if_en),
        .if_to_ic_pc     (if_pc),
        .ic_to_if_done   (if_done),
        .ic_to_if_inst   (if_inst),
        .ic_to_mc_enable (mc_en),
        .ic_to_mc_pc     (mc_pc),
        .mc_to_ic_done   (mc_done),
        .mc_to_ic_result (mc_res)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        for (int i = 0; i < 256; i++) m_valid[i] = 1'b0;
    endtask

    task automatic model_fill(input logic [31:0] pc, input logic [31:0] d);
        logic [7:0] ix;
        ix = pc[9:2];
        m_valid[ix] = 1'b1;
        m_tag[ix]   = pc[17:10];
        m_data[ix]  = d;
    endtask

    // Drives one fetch and, on a miss, plays the memory controller.
    // clr_at: -2 none, -1 on the request cycle, k>=0 k cycles after issue.
    // lat: cycle (after issue) on which mc_to_ic_done is pulsed.
    task automatic run_fetch(input logic [31:0] pc, input logic [31:0] rdata,
                             input int lat, input int clr_at,
                             input int frz_at, input int frz_len, input bit hold_req,
                             output bit hit, output bit miss, output bit miss_ok,
                             output bit got_done, output logic [31:0] got_inst,
                             output bit hold_ok, output bit timeout);
        int c;
        hit = 0; miss = 0; miss_ok = 1; got_done = 0; got_inst = '0;
        hold_ok = 1; timeout = 0;
        if_en = 1'b1; if_pc = pc; clr = (clr_at == -1);
        step();
        if_en = 1'b0; clr = 1'b0;
        if (if_done) begin
            hit = 1; got_done = 1; got_inst = if_inst;
            if (mc_en) miss_ok = 0;
            return;
        end
        if (!mc_en) begin
            if (if_inst !== 32'h0) miss_ok = 0;
            return;
        end
        miss = 1;
        if (mc_pc !== pc) miss_ok = 0;
        c = 0;
        forever begin
            if (c > 60) begin
                timeout = 1;
                return;
            end
            rdy = !(c >= frz_at && c < frz_at + frz_len);
            clr = (c == clr_at);
            if (c == lat) begin
                mc_done = 1'b1; mc_res = rdata;
            end
            step();
            rdy = 1'b1; clr = 1'b0; mc_done = 1'b0; mc_res = $urandom;
            if (c == lat) begin
                got_done = if_done; got_inst = if_inst;
                if (mc_en) hold_ok = 0;
                break;
            end
            if (!mc_en || mc_pc !== pc || if_done || if_inst !== 32'h0) miss_ok = 0;
            c++;
        end
        if (hold_req) begin
            if_en = 1'b1; if_pc = pc ^ 32'h0000_0400;
        end
        step();
        if_en = 1'b0;
        if (if_done || mc_en) hold_ok = 0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        n_cmp++; if (if_done !== 1'b0) begin n_bad++; $display("FAIL reset_done got %b want 0", if_done); end
        n_cmp++; if (if_inst !== 32'h0) begin n_bad++; $display("FAIL reset_inst got %h want 0", if_inst); end
        n_cmp++; if (mc_en !== 1'b0) begin n_bad++; $display("FAIL reset_mc_en got %b want 0", mc_en); end
        n_cmp++; if (mc_pc !== 32'h0) begin n_bad++; $display("FAIL reset_mc_pc got %h want 0", mc_pc); end
        rst = 1'b0;
        model_clear();
    endtask

    task automatic test_cold_miss();
        bit h, m, mok, d, hok, to; logic [31:0] ins;
        run_fetch(32'h4, 32'h0010_0093, 3, -2, 100, 0, 1'b0, h, m, mok, d, ins, hok, to);
        n_cmp++; if ({m, mok, to} !== 3'b110) begin n_bad++; $display("FAIL cold_miss_issue got m=%b ok=%b to=%b want 1 1 0", m, mok, to); end
        n_cmp++; if (d !== 1'b1 || ins !== 32'h0010_0093) begin n_bad++; $display("FAIL cold_fill_fwd got %b/%h want 1/00100093", d, ins); end
        n_cmp++; if (hok !== 1'b1) begin n_bad++; $display("FAIL cold_hold got bad want clean"); end
        model_fill(32'h4, 32'h0010_0093);
    endtask

    task automatic test_hit();
        bit h, m, mok, d, hok, to; logic [31:0] ins;
        run_fetch(32'h4, 32'hFFFF_FFFF, 3, -2, 100, 0, 1'b0, h, m, mok, d, ins, hok, to);
        n_cmp++; if ({h, mok} !== 2'b11) begin n_bad++; $display("FAIL hit_detect got h=%b ok=%b want 1 1", h, mok); end
        n_cmp++; if (ins !== 32'h0010_0093) begin n_bad++; $display("FAIL hit_inst got %h want 00100093", ins); end
    endtask

    task automatic test_conflict();
        bit h, m, mok, d, hok, to; logic [31:0] ins;
        run_fetch(32'h404, 32'hDEAD_0404, 2, -2, 100, 0, 1'b0, h, m, mok, d, ins, hok, to);
        n_cmp++; if ({m, mok, d} !== 3'b111 || ins !== 32'hDEAD_0404) begin n_bad++; $display("FAIL conflict_miss got m=%b ok=%b d=%b %h want 1 1 1 dead0404", m, mok, d, ins); end
        model_fill(32'h404, 32'hDEAD_0404);
        run_fetch(32'h4, 32'h0010_0093, 1, -2, 100, 0, 1'b0, h, m, mok, d, ins, hok, to);
        n_cmp++; if ({m, d} !== 2'b11 || ins !== 32'h0010_0093) begin n_bad++; $display("FAIL conflict_remiss got m=%b d=%b %h want 1 1 00100093", m, d, ins); end
        model_fill(32'h4, 32'h0010_0093);
    endtask

    task automatic test_flush();
        bit h, m, mok, d, hok, to; logic [31:0] ins;
        run_fetch(32'h8, 32'h0000_0013, 4, 1, 100, 0, 1'b0, h, m, mok, d, ins, hok, to);
        n_cmp++; if ({m, d} !== 2'b10) begin n_bad++; $display("FAIL flush_mid_miss got m=%b d=%b want 1 0", m, d); end
        run_fetch(32'h8, 32'h1111_1111, 2, -2, 100, 0, 1'b0, h, m, mok, d, ins, hok, to);
        n_cmp++; if (h !== 1'b1 || ins !== 32'h0000_0013) begin n_bad++; $display("FAIL flush_then_hit got h=%b %h want 1 00000013", h, ins); end
        run_fetch(32'hC, 32'h0C0C_0C0C, 2, 2, 100, 0, 1'b0, h, m, mok, d, ins, hok, to);
        n_cmp++; if ({m, d, hok} !== 3'b101) begin n_bad++; $display("FAIL flush_coincident got m=%b d=%b hold=%b want 1 0 1", m, d, hok); end
        run_fetch(32'h10, 32'h1010_1010, 2, -1, 100, 0, 1'b0, h, m, mok, d, ins, hok, to);
        n_cmp++; if ({m, d, mok} !== 3'b001) begin n_bad++; $display("FAIL flush_idle got m=%b d=%b ok=%b want 0 0 1", m, d, mok); end
        run_fetch(32'h10, 32'h1010_1010, 1, -2, 100, 0, 1'b1, h, m, mok, d, ins, hok, to);
        n_cmp++; if ({m, d, hok} !== 3'b111) begin n_bad++; $display("FAIL flush_idle_refetch got m=%b d=%b hold=%b want 1 1 1", m, d, hok); end
        model_fill(32'h8, 32'h0000_0013);
        model_fill(32'hC, 32'h0C0C_0C0C);
        model_fill(32'h10, 32'h1010_1010);
    endtask

    task automatic test_freeze();
        bit h, m, mok, d, hok, to; logic [31:0] ins;
        run_fetch(32'h20, 32'h2020_ABCD, 6, -2, 1, 3, 1'b0, h, m, mok, d, ins, hok, to);
        n_cmp++; if ({m, mok, to} !== 3'b110) begin n_bad++; $display("FAIL freeze_hold got m=%b ok=%b to=%b want 1 1 0", m, mok, to); end
        n_cmp++; if (d !== 1'b1 || ins !== 32'h2020_ABCD) begin n_bad++; $display("FAIL freeze_complete got %b/%h want 1/2020abcd", d, ins); end
        model_fill(32'h20, 32'h2020_ABCD);
    endtask

    task automatic test_reset_mid_miss();
        bit h, m, mok, d, hok, to; logic [31:0] ins;
        if_en = 1'b1; if_pc = 32'h30;
        step();
        if_en = 1'b0;
        n_cmp++; if (mc_en !== 1'b1) begin n_bad++; $display("FAIL rstmiss_issue got %b want 1", mc_en); end
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        n_cmp++; if ({if_done, mc_en} !== 2'b00 || if_inst !== 32'h0 || mc_pc !== 32'h0) begin
            n_bad++; $display("FAIL rstmiss_outputs got d=%b e=%b i=%h p=%h want all 0", if_done, mc_en, if_inst, mc_pc);
        end
        model_clear();
        run_fetch(32'h4, 32'h0010_0093, 2, -2, 100, 0, 1'b0, h, m, mok, d, ins, hok, to);
        n_cmp++; if ({m, d} !== 2'b11 || ins !== 32'h0010_0093) begin n_bad++; $display("FAIL rstmiss_refetch got m=%b d=%b %h want 1 1 00100093", m, d, ins); end
        model_fill(32'h4, 32'h0010_0093);
    endtask

    task automatic test_random();
        bit h, m, mok, d, hok, to, hreq, exp_done;
        logic [31:0] ins, pc, rd;
        logic [7:0] ix;
        int lat, clr_at, frz_at, frz_len, mode, idle;
        for (int it = 0; it < 200; it++) begin
            pc = $urandom;
            pc[1:0] = 2'b00;
            pc[9:2] = 8'($urandom_range(0, 7));
            pc[17:10] = 8'($urandom_range(0, 2));
            ix = pc[9:2];
            rd = $urandom;
            lat = $urandom_range(0, 5);
            mode = $urandom_range(0, 9);
            frz_at = 100; frz_len = 0; clr_at = -2;
            if (mode == 0) clr_at = -1;
            else if (mode <= 2) clr_at = $urandom_range(0, lat);
            else if (lat >= 3 && $urandom_range(0, 2) == 0) begin
                frz_at = 1; frz_len = lat - 1;
            end
            hreq = 1'($urandom_range(0, 1));
            run_fetch(pc, rd, lat, clr_at, frz_at, frz_len, hreq, h, m, mok, d, ins, hok, to);
            if (clr_at == -1) begin
                n_cmp++; if ({m, d, mok} !== 3'b001) begin n_bad++; $display("FAIL rnd_clr_idle it=%0d got m=%b d=%b ok=%b want 0 0 1", it, m, d, mok); end
            end else if (m_valid[ix] && m_tag[ix] == pc[17:10]) begin
                n_cmp++; if ({h, mok} !== 2'b11 || ins !== m_data[ix]) begin n_bad++; $display("FAIL rnd_hit it=%0d pc=%h got h=%b %h want 1 %h", it, pc, h, ins, m_data[ix]); end
            end else begin
                exp_done = !(clr_at >= 0 && clr_at <= lat);
                n_cmp++; if ({m, mok, to, hok} !== 4'b1101) begin n_bad++; $display("FAIL rnd_miss it=%0d pc=%h got m=%b ok=%b to=%b hold=%b want 1 1 0 1", it, pc, m, mok, to, hok); end
                n_cmp++; if (d !== exp_done || (exp_done && ins !== rd)) begin n_bad++; $display("FAIL rnd_fill it=%0d got %b/%h want %b/%h", it, d, ins, exp_done, rd); end
                model_fill(pc, rd);
            end
            idle = $urandom_range(0, 2);
            for (int k = 0; k < idle; k++) begin
                step();
                n_cmp++; if ({if_done, mc_en} !== 2'b00 || if_inst !== 32'h0) begin n_bad++; $display("FAIL rnd_idle it=%0d got d=%b e=%b i=%h want 0", it, if_done, mc_en, if_inst); end
            end
        end
    endtask

    initial begin
        rst = 1'b1; rdy = 1'b1; clr = 1'b0; if_en = 1'b0; if_pc = '0;
        mc_done = 1'b0; mc_res = '0;
        test_reset();
        test_cold_miss();
        test_hit();
        test_conflict();
        test_flush();
        test_freeze();
        test_reset_mid_miss();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired at %0t, want completion", $time);
        $fatal(1);
    end

endmodule
